// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand fetch stage.
package operand_fetch_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } state_t;

    // A writeback hits idx only when it is enabled (active-low) and targets a non-zero register.
    function automatic logic write_matches(input logic [REG_IDX_W-1:0] rd,
                                           input logic                 enablen,
                                           input logic [REG_IDX_W-1:0] idx);
        return !enablen && (rd != REG_ZERO) && (rd == idx);
    endfunction

endpackage

// File: rtl/operand_fetch_bypass.sv
// One operand's writeback match and the priority select used when read data returns.
module operand_bypass
    import operand_fetch_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idx,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 wb_enablen,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 pending,
    input  logic [XLEN-1:0]      pending_data,
    input  logic [XLEN-1:0]      rf_rdata,
    output logic                 match,
    output logic [XLEN-1:0]      value
);

    assign match = write_matches(wb_rd, wb_enablen, idx);

    // A write landing now is newer than one captured at issue, which is newer than the array.
    always_comb begin
        value = rf_rdata;
        if (idx == REG_ZERO) begin
            value = '0;
        end else if (match) begin
            value = wb_data;
        end else if (pending) begin
            value = pending_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Issues register-file reads for one instruction and hands snoop-corrected operands to execute.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    output logic [REG_IDX_W-1:0] rf_rs1,
    output logic [REG_IDX_W-1:0] rf_rs2,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 wb_enablen,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_op1,
    output logic [XLEN-1:0]      out_op2
);

    state_t state;
    state_t next_state;

    logic [REG_IDX_W-1:0] rs1_q;
    logic [REG_IDX_W-1:0] rs2_q;
    logic                 pend1;
    logic                 pend2;
    logic [XLEN-1:0]      pend_data1;
    logic [XLEN-1:0]      pend_data2;

    logic            accept;
    logic            match1;
    logic            match2;
    logic [XLEN-1:0] value1;
    logic [XLEN-1:0] value2;

    assign in_ready  = !reset && ((state == IDLE) || ((state == VALID) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == VALID);

    assign rf_rs1 = accept ? in_rs1 : rs1_q;
    assign rf_rs2 = accept ? in_rs2 : rs2_q;

    operand_bypass u_bypass1 (
        .idx          (rs1_q),
        .wb_rd        (wb_rd),
        .wb_enablen   (wb_enablen),
        .wb_data      (wb_data),
        .pending      (pend1),
        .pending_data (pend_data1),
        .rf_rdata     (rf_rdata1),
        .match        (match1),
        .value        (value1)
    );

    operand_bypass u_bypass2 (
        .idx          (rs2_q),
        .wb_rd        (wb_rd),
        .wb_enablen   (wb_enablen),
        .wb_data      (wb_data),
        .pending      (pend2),
        .pending_data (pend_data2),
        .rf_rdata     (rf_rdata2),
        .match        (match2),
        .value        (value2)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = WAIT;
            WAIT:    next_state = VALID;
            VALID: begin
                if (accept) begin
                    next_state = WAIT;
                end else if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rs1_q      <= REG_ZERO;
            rs2_q      <= REG_ZERO;
            out_pc     <= '0;
            out_op1    <= '0;
            out_op2    <= '0;
            pend1      <= 1'b0;
            pend2      <= 1'b0;
            pend_data1 <= '0;
            pend_data2 <= '0;
        end else begin
            state <= next_state;
            // The array returns the pre-write value for a same-cycle write, so remember it here.
            if (accept) begin
                rs1_q      <= in_rs1;
                rs2_q      <= in_rs2;
                out_pc     <= in_pc;
                pend1      <= write_matches(wb_rd, wb_enablen, in_rs1);
                pend2      <= write_matches(wb_rd, wb_enablen, in_rs2);
                pend_data1 <= wb_data;
                pend_data2 <= wb_data;
            end
            if (state == WAIT) begin
                out_op1 <= value1;
                out_op2 <= value2;
                pend1   <= 1'b0;
                pend2   <= 1'b0;
            end else if (state == VALID) begin
                if (match1) out_op1 <= wb_data;
                if (match2) out_op2 <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a registered-read register file model.
module tb_operand_fetch;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [4:0]  wb_rd;
    logic        wb_enablen;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_op1;
    logic [31:0] out_op2;

    logic        rf_clear;
    logic [31:0] regs [32];
    int          checks;
    int          passes;

    operand_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .rf_rs1     (rf_rs1),
        .rf_rs2     (rf_rs2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .wb_rd      (wb_rd),
        .wb_enablen (wb_enablen),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_op1    (out_op1),
        .out_op2    (out_op2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: registered read, no internal write-to-read forwarding.
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
            rf_rdata1 <= 32'h0;
            rf_rdata2 <= 32'h0;
        end else begin
            rf_rdata1 <= regs[rf_rs1];
            rf_rdata2 <= regs[rf_rs2];
            if (!wb_enablen && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
        wb_rd      = idx;
        wb_data    = data;
        wb_enablen = 1'b0;
        tick();
        wb_enablen = 1'b1;
        wb_rd      = 5'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid); else passes++;
        checks++; if (out_pc !== 32'h0) $display("[TB] FAIL reset_out_pc got %h exp 0", out_pc); else passes++;
        checks++; if (out_op1 !== 32'h0 || out_op2 !== 32'h0) $display("[TB] FAIL reset_ops got %h/%h exp 0/0", out_op1, out_op2); else passes++;
        checks++; if (rf_rs1 !== 5'd0 || rf_rs2 !== 5'd0) $display("[TB] FAIL reset_rf_idx got %0d/%0d exp 0/0", rf_rs1, rf_rs2); else passes++;
        checks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready_held got %b exp 0", in_ready); else passes++;
        reset    = 1'b0;
        rf_clear = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready_released got %b exp 1", in_ready); else passes++;
    endtask

    task automatic test_basic_read();
        write_reg(5'd5, 32'h1234_5678);
        write_reg(5'd6, 32'hDEAD_BEEF);
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; in_pc = 32'h100; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL basic_in_ready got %b exp 1", in_ready); else passes++;
        checks++; if (rf_rs1 !== 5'd5 || rf_rs2 !== 5'd6) $display("[TB] FAIL basic_rf_idx got %0d/%0d exp 5/6", rf_rs1, rf_rs2); else passes++;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL basic_wait_valid got %b exp 0", out_valid); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL basic_out_valid got %b exp 1", out_valid); else passes++;
        checks++; if (out_op1 !== 32'h1234_5678) $display("[TB] FAIL basic_op1 got %h exp 12345678", out_op1); else passes++;
        checks++; if (out_op2 !== 32'hDEAD_BEEF) $display("[TB] FAIL basic_op2 got %h exp deadbeef", out_op2); else passes++;
        checks++; if (out_pc !== 32'h100) $display("[TB] FAIL basic_pc got %h exp 100", out_pc); else passes++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL basic_drain got %b exp 0", out_valid); else passes++;
    endtask

    task automatic test_issue_bypass();
        write_reg(5'd7, 32'h11);
        in_valid = 1'b1; in_rs1 = 5'd7; in_rs2 = 5'd0; in_pc = 32'h104;
        wb_rd = 5'd7; wb_data = 32'h22; wb_enablen = 1'b0;
        tick();
        in_valid = 1'b0; wb_enablen = 1'b1;
        tick();
        checks++; if (out_op1 !== 32'h22) $display("[TB] FAIL issue_bypass_op1 got %h exp 22", out_op1); else passes++;
        checks++; if (out_op2 !== 32'h0) $display("[TB] FAIL issue_bypass_op2 got %h exp 0", out_op2); else passes++;
        tick();
    endtask

    task automatic test_wait_bypass();
        write_reg(5'd7, 32'h11);
        in_valid = 1'b1; in_rs1 = 5'd7; in_rs2 = 5'd7; in_pc = 32'h108;
        wb_rd = 5'd7; wb_data = 32'h22; wb_enablen = 1'b0;
        tick();
        in_valid = 1'b0; wb_data = 32'h33;
        tick();
        wb_enablen = 1'b1;
        checks++; if (out_op1 !== 32'h33) $display("[TB] FAIL wait_bypass_op1 got %h exp 33", out_op1); else passes++;
        checks++; if (out_op2 !== 32'h33) $display("[TB] FAIL wait_bypass_op2 got %h exp 33", out_op2); else passes++;
        tick();
    endtask

    task automatic test_hold_snoop();
        write_reg(5'd8, 32'h77);
        write_reg(5'd9, 32'h5555);
        in_valid = 1'b1; in_rs1 = 5'd8; in_rs2 = 5'd9; in_pc = 32'h200; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (out_op2 !== 32'h5555) $display("[TB] FAIL hold_op2_first got %h exp 5555", out_op2); else passes++;
        checks++; if (in_ready !== 1'b0) $display("[TB] FAIL hold_in_ready got %b exp 0", in_ready); else passes++;
        tick();
        wb_rd = 5'd9; wb_data = 32'hCAFE; wb_enablen = 1'b0;
        #1;
        checks++; if (out_op2 !== 32'h5555) $display("[TB] FAIL hold_op2_before_update got %h exp 5555", out_op2); else passes++;
        tick();
        wb_enablen = 1'b1;
        checks++; if (out_op2 !== 32'hCAFE) $display("[TB] FAIL hold_op2_snooped got %h exp cafe", out_op2); else passes++;
        checks++; if (out_op1 !== 32'h77) $display("[TB] FAIL hold_op1 got %h exp 77", out_op1); else passes++;
        checks++; if (out_pc !== 32'h200) $display("[TB] FAIL hold_pc got %h exp 200", out_pc); else passes++;
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL hold_valid got %b exp 1", out_valid); else passes++;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL hold_drain got %b exp 0", out_valid); else passes++;
    endtask

    task automatic test_zero_reg();
        in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_pc = 32'h300;
        wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF; wb_enablen = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        wb_enablen = 1'b1;
        checks++; if (out_op1 !== 32'h0 || out_op2 !== 32'h0) $display("[TB] FAIL zero_ops got %h/%h exp 0/0", out_op1, out_op2); else passes++;
        tick();
        in_valid = 1'b1; in_rs1 = 5'd7; in_rs2 = 5'd7; in_pc = 32'h304;
        wb_rd = 5'd7; wb_data = 32'h99; wb_enablen = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (out_op1 !== 32'h33 || out_op2 !== 32'h33) $display("[TB] FAIL disabled_write_ops got %h/%h exp 33/33", out_op1, out_op2); else passes++;
        wb_rd = 5'd0;
        tick();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; in_pc = 32'h400;
        tick();
        in_valid = 1'b0; reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("[TB] FAIL mid_reset_in_ready got %b exp 0", in_ready); else passes++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_reset_valid got %b exp 0", out_valid); else passes++;
        checks++; if (out_op1 !== 32'h0 || out_pc !== 32'h0) $display("[TB] FAIL mid_reset_outputs got op1 %h pc %h exp 0/0", out_op1, out_pc); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL mid_reset_ready_after got %b exp 1", in_ready); else passes++;
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd0; in_pc = 32'h404;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_reset_wait got %b exp 0", out_valid); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1 || out_op1 !== 32'h1234_5678) $display("[TB] FAIL mid_reset_fresh got valid %b op1 %h exp 1/12345678", out_valid, out_op1); else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        write_reg(5'd10, 32'hA0);
        write_reg(5'd11, 32'hB0);
        in_valid = 1'b1; in_rs1 = 5'd10; in_rs2 = 5'd11; in_pc = 32'h500; out_ready = 1'b1;
        tick();
        in_rs1 = 5'd11; in_rs2 = 5'd10; in_pc = 32'h504;
        #1;
        checks++; if (in_ready !== 1'b0) $display("[TB] FAIL b2b_wait_ready got %b exp 0", in_ready); else passes++;
        tick();
        checks++; if (out_op1 !== 32'hA0 || out_pc !== 32'h500) $display("[TB] FAIL b2b_first got op1 %h pc %h exp a0/500", out_op1, out_pc); else passes++;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL b2b_valid_ready got %b exp 1", in_ready); else passes++;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL b2b_second_wait got %b exp 0", out_valid); else passes++;
        tick();
        checks++; if (out_op1 !== 32'hB0 || out_op2 !== 32'hA0 || out_pc !== 32'h504) $display("[TB] FAIL b2b_second got %h/%h pc %h exp b0/a0/504", out_op1, out_op2, out_pc); else passes++;
        tick();
    endtask

    task automatic test_same_index();
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd5; in_pc = 32'h600;
        wb_rd = 5'd5; wb_data = 32'hABCD; wb_enablen = 1'b0;
        tick();
        in_valid = 1'b0; wb_enablen = 1'b1;
        tick();
        checks++; if (out_op1 !== 32'hABCD || out_op2 !== 32'hABCD) $display("[TB] FAIL same_index got %h/%h exp abcd/abcd", out_op1, out_op2); else passes++;
        tick();
    endtask

    initial begin
        checks = 0; passes = 0;
        rf_clear = 1'b1; reset = 1'b1;
        in_valid = 1'b0; in_pc = 32'h0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        wb_rd = 5'd0; wb_enablen = 1'b1; wb_data = 32'h0; out_ready = 1'b0;
        tick();
        test_reset();
        test_basic_read();
        test_issue_bypass();
        test_wait_bypass();
        test_hold_snoop();
        test_zero_reg();
        test_reset_mid();
        test_back_to_back();
        test_same_index();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
